// File: rtl/vot3_colect.sv
// vot3_colect: vote-collection front end for the vot3 majority voter.
// A start pulse opens a session. Each of the three voters records one
// yes/no vote, and the first valid press locks that vote. The session
// closes when all three have voted, or after TIMEOUT_CYCLES edges in
// COLLECT. The DONE state then raises a one-cycle ready strobe.
// Handshake: ready is a one-cycle valid with no back-pressure. v1..v3 are
// valid while ready=1 and stay unchanged until the next session opens.
module vot3_colect #(
  parameter int TIMEOUT_CYCLES = 16,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] btn_yes,
  input  logic [2:0] btn_no,
  output logic       v1,
  output logic       v2,
  output logic       v3,
  output logic [2:0] voted,
  output logic       busy,
  output logic       ready,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       vote_q, vote_d;
  logic [2:0]       voted_q, voted_d;
  logic             timeout_q, timeout_d;

  // Last COLLECT edge before the session is force-closed.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      vote_q    <= '0;
      voted_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vote_q    <= vote_d;
      voted_q   <= voted_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: session open, per-voter vote capture, and exit decision.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vote_d    = vote_q;
    voted_d   = voted_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_COLLECT;
          cnt_d     = '0;
          vote_d    = '0;
          voted_d   = '0;
          timeout_d = 1'b0;
        end
      end
      S_COLLECT: begin
        cnt_d = cnt_q + 1'b1;
        // A press counts only when exactly one of yes/no is high.
        // A simultaneous yes+no press is dropped.
        for (int i = 0; i < 3; i++) begin
          if (!voted_q[i] && (btn_yes[i] ^ btn_no[i])) begin
            vote_d[i]  = btn_yes[i];
            voted_d[i] = 1'b1;
          end
        end
        // Completion takes priority over timeout on the same edge.
        if (&voted_d) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if (cnt_q == LAST_CNT) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All outputs decode directly from registers.
  assign v1      = vote_q[0];
  assign v2      = vote_q[1];
  assign v3      = vote_q[2];
  assign voted   = voted_q;
  assign busy    = (state_q != S_IDLE);
  assign ready   = (state_q == S_DONE);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_vot3_colect.sv
// Bench for vot3_colect: a session-level model checked on every falling edge,
// plus directed sessions with hand-computed literal expectations.
module tb_vot3_colect;

  localparam int TO = 16;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] btn_yes;
  logic [2:0] btn_no;
  logic       v1, v2, v3;
  logic [2:0] voted;
  logic       busy, ready, timeout;

  int checks = 0;
  int errors = 0;

  vot3_colect #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .btn_yes (btn_yes),
    .btn_no  (btn_no),
    .v1      (v1),
    .v2      (v2),
    .v3      (v3),
    .voted   (voted),
    .busy    (busy),
    .ready   (ready),
    .timeout (timeout)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Session model: the phase of the session, the number of edges elapsed
  // since it opened, and each voter's recorded vote.
  int m_phase;   // 0 idle, 1 collecting, 2 closed (result shown)
  int m_edges;
  bit m_v[3];
  bit m_voted[3];
  bit m_to;

  // Model update: reset is asynchronous; otherwise the model advances one
  // step per rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_edges = 0; m_to = 0;
      for (int i = 0; i < 3; i++) begin m_v[i] = 0; m_voted[i] = 0; end
    end else begin
      if (m_phase == 0) begin
        if (start) begin
          m_phase = 1; m_edges = 0; m_to = 0;
          for (int i = 0; i < 3; i++) begin m_v[i] = 0; m_voted[i] = 0; end
        end
      end else if (m_phase == 1) begin
        int nvoted;
        m_edges = m_edges + 1;
        nvoted = 0;
        for (int i = 0; i < 3; i++) begin
          if (!m_voted[i] && btn_yes[i] && !btn_no[i]) begin m_v[i] = 1; m_voted[i] = 1; end
          if (!m_voted[i] && btn_no[i] && !btn_yes[i]) begin m_v[i] = 0; m_voted[i] = 1; end
          if (m_voted[i]) nvoted++;
        end
        if (nvoted == 3) begin m_phase = 2; m_to = 0; end
        else if (m_edges == TO) begin m_phase = 2; m_to = 1; end
      end else begin
        m_phase = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are stable on the falling edge.
  always @(negedge clk) begin
    chk("model_vote", {29'd0, v3, v2, v1}, {29'd0, m_v[2], m_v[1], m_v[0]});
    chk("model_voted", {29'd0, voted}, {29'd0, m_voted[2], m_voted[1], m_voted[0]});
    chk("model_busy", {31'd0, busy}, {31'd0, m_phase != 0});
    chk("model_ready", {31'd0, ready}, {31'd0, m_phase == 2});
    chk("model_timeout", {31'd0, timeout}, {31'd0, m_to});
  end

  // Driver tasks: each is entered on a falling edge and consumes one rising edge.
  task automatic drive(input logic [2:0] y, input logic [2:0] n, input logic s);
    btn_yes = y; btn_no = n; start = s;
    @(negedge clk);
    btn_yes = 3'b000; btn_no = 3'b000; start = 1'b0;
  endtask

  task automatic open_session();
    drive(3'b000, 3'b000, 1'b1);
  endtask

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Directed sessions.
  initial begin
    rst_n = 1'b0; start = 1'b0; btn_yes = 3'b000; btn_no = 3'b000;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_vote", {29'd0, v3, v2, v1}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All three vote yes on the first edge; ready two edges after start.
    open_session();
    chk("t1_ready_early", {31'd0, ready}, 32'd0);
    drive(3'b111, 3'b000, 1'b0);
    chk("t1_ready", {31'd0, ready}, 32'd1);
    chk("t1_vote", {29'd0, v3, v2, v1}, 32'b111);
    chk("t1_timeout", {31'd0, timeout}, 32'd0);
    chk("t1_vot", {31'd0, maj(v1, v2, v3)}, 32'd1);
    drive(3'b000, 3'b000, 1'b0);
    chk("t1_ready_one_cycle", {31'd0, ready}, 32'd0);
    chk("t1_hold", {29'd0, v3, v2, v1}, 32'b111);

    // Spread votes over edges 1, 3 and 5.
    open_session();
    drive(3'b001, 3'b000, 1'b0);
    drive(3'b000, 3'b000, 1'b0);
    drive(3'b000, 3'b010, 1'b0);
    drive(3'b000, 3'b000, 1'b0);
    chk("t2_not_ready", {31'd0, ready}, 32'd0);
    drive(3'b100, 3'b000, 1'b0);
    chk("t2_ready", {31'd0, ready}, 32'd1);
    chk("t2_vote", {29'd0, v3, v2, v1}, 32'b101);
    chk("t2_vot", {31'd0, maj(v1, v2, v3)}, 32'd1);
    drive(3'b000, 3'b000, 1'b0);

    // The first vote locks; a later "no" from voter 1 is ignored.
    open_session();
    drive(3'b001, 3'b000, 1'b0);
    drive(3'b010, 3'b001, 1'b0);
    chk("t3_voted", {29'd0, voted}, 32'b011);
    drive(3'b000, 3'b100, 1'b0);
    chk("t3_ready", {31'd0, ready}, 32'd1);
    chk("t3_vote", {29'd0, v3, v2, v1}, 32'b011);
    chk("t3_vot", {31'd0, maj(v1, v2, v3)}, 32'd1);
    drive(3'b000, 3'b000, 1'b0);

    // Timeout: only voter 1 votes, on edge 2; the session closes on edge 16.
    open_session();
    drive(3'b000, 3'b000, 1'b0);
    drive(3'b001, 3'b000, 1'b0);
    repeat (13) drive(3'b000, 3'b000, 1'b0);
    chk("t4_not_ready_e15", {31'd0, ready}, 32'd0);
    chk("t4_busy_e15", {31'd0, busy}, 32'd1);
    drive(3'b000, 3'b000, 1'b0);
    chk("t4_ready", {31'd0, ready}, 32'd1);
    chk("t4_timeout", {31'd0, timeout}, 32'd1);
    chk("t4_voted", {29'd0, voted}, 32'b001);
    chk("t4_vote", {29'd0, v3, v2, v1}, 32'b001);
    chk("t4_vot", {31'd0, maj(v1, v2, v3)}, 32'd0);
    drive(3'b000, 3'b000, 1'b0);
    chk("t4_timeout_sticky", {31'd0, timeout}, 32'd1);

    // An invalid yes+no press is dropped; a later "no" is then recorded.
    open_session();
    chk("t5_timeout_cleared", {31'd0, timeout}, 32'd0);
    drive(3'b010, 3'b010, 1'b0);
    chk("t5_dropped", {29'd0, voted}, 32'b000);
    drive(3'b000, 3'b010, 1'b0);
    chk("t5_voted", {29'd0, voted}, 32'b010);
    chk("t5_v2", {31'd0, v2}, 32'd0);
    drive(3'b101, 3'b000, 1'b0);
    chk("t5_ready", {31'd0, ready}, 32'd1);
    chk("t5_vote", {29'd0, v3, v2, v1}, 32'b101);
    drive(3'b000, 3'b000, 1'b0);

    // Asynchronous reset in the middle of COLLECT with voted=011.
    open_session();
    drive(3'b001, 3'b000, 1'b1);
    drive(3'b000, 3'b010, 1'b1);
    chk("t6_voted_pre", {29'd0, voted}, 32'b011);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_voted", {29'd0, voted}, 32'd0);
    chk("t6_async_vote", {29'd0, v3, v2, v1}, 32'd0);
    chk("t6_async_busy", {31'd0, busy}, 32'd0);
    chk("t6_async_ready_to", {30'd0, ready, timeout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_busy_after", {31'd0, busy}, 32'd0);

    // start held through COLLECT and DONE does not restart the session.
    open_session();
    drive(3'b001, 3'b000, 1'b1);
    drive(3'b110, 3'b000, 1'b1);
    chk("t7_ready", {31'd0, ready}, 32'd1);
    chk("t7_vote", {29'd0, v3, v2, v1}, 32'b111);
    drive(3'b000, 3'b000, 1'b1);
    chk("t7_idle", {31'd0, busy}, 32'd0);
    chk("t7_hold", {29'd0, v3, v2, v1}, 32'b111);
    drive(3'b000, 3'b000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vot3_colect.md
Name: vot3_colect

Overview:
- Upstream vote-collection stage for the vot3 majority voter.
- Opens a voting session on a start pulse and captures one vote per voter (yes or no) from per-voter button pulses.
- Closes the session when all three voters have voted or when a timeout expires, then presents stable v1/v2/v3 to vot3 with a one-cycle ready strobe.
- Replaces the free-running stimulus generator in system-level benches and on the lab board.

Parameters:
- TIMEOUT_CYCLES, 16, number of clock edges spent in COLLECT before the session is force-closed; legal range 2..255.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), width of the internal session counter; derived, not overridden.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  session open request, sampled only in IDLE.
- btn_yes  input  3  per-voter yes pulse; bit i belongs to voter i+1.
- btn_no  input  3  per-voter no pulse; bit i belongs to voter i+1.
- v1  output  1  registered vote of voter 1 (1 = yes); feeds vot3.v1.
- v2  output  1  registered vote of voter 2; feeds vot3.v2.
- v3  output  1  registered vote of voter 3; feeds vot3.v3.
- voted  output  3  per-voter "vote recorded" flags for the current session.
- busy  output  1  high in COLLECT and DONE.
- ready  output  1  one-cycle strobe: v1..v3 final and valid.
- timeout  output  1  last session closed by timeout; sticky until the next start.

Behaviour:
- One clock and one reset: clk, rst_n. Reset is asynchronous and active-low.
- All outputs are registered, with no combinational paths from inputs to outputs.
- Reset (rst_n=0, any time, including mid-session): state=IDLE, v1=v2=v3=0, voted=000, busy=0, ready=0, timeout=0, counter=0. Takes effect immediately, without waiting for a clock edge.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - busy=0. v1..v3 and timeout hold the previous session's values.
  - On an edge with start=1: go to COLLECT; clear voted, v1..v3, timeout and counter.
  - btn_yes/btn_no are ignored in IDLE.
- COLLECT:
  - busy=1. The counter increments on every edge spent in COLLECT.
  - For each voter i with voted[i]=0, on an edge:
    - btn_yes[i]=1 and btn_no[i]=0: v(i+1)<=1, voted[i]<=1.
    - btn_no[i]=1 and btn_yes[i]=0: v(i+1)<=0, voted[i]<=1.
    - Both high or both low: no change. The simultaneous yes+no case is an invalid press and is dropped.
  - If voted[i]=1, further presses from voter i are ignored; the first valid vote locks.
  - Voters are independent. Any number of voters may vote on the same edge.
  - start is ignored in COLLECT; no restart.
- COLLECT exit:
  - Completion: on an edge where all three voted bits are 1, counting votes recorded on that same edge, go to DONE with timeout=0.
  - Timeout: on the TIMEOUT_CYCLES-th COLLECT edge (counter==TIMEOUT_CYCLES-1) without completion, go to DONE and set timeout=1.
    - Votes presented on that final edge are still recorded.
    - Voters still unvoted keep v=0, meaning absence counts as "no".
  - If completion and timeout fall on the same edge, completion wins: timeout=0.
- DONE:
  - Lasts exactly one cycle. ready=1 and busy=1. Next state is always IDLE.
  - start is ignored in DONE. A start must be seen in IDLE, i.e. at least one cycle after DONE.
- ready is high only during DONE, so it is 1 cycle wide.
- Latency:
  - start sampled at edge k; all votes presented before edge k+1 → DONE and ready=1 in the cycle after edge k+1.
  - Minimum start-to-ready is 2 edges.
- v1..v3 are stable from DONE until the next session opens. vot3 output is valid whenever ready=1, and afterwards until the next start.
- Counter width is CNT_W. The counter never wraps, because COLLECT exits at TIMEOUT_CYCLES-1.

Test Plan:
- Reset, then start pulse; edge 1: btn_yes=111 → voted=111, v1..v3=111, ready=1 for one cycle two edges after start, timeout=0, vot=1.
- Start; btn_yes=001 at edge 1, btn_no=010 at edge 3, btn_yes=100 at edge 5 → v3v2v1=101, ready=1 after edge 5, vot=1.
- Start; btn_yes=001 then btn_no=001 on a later edge; plus btn_yes=010 and btn_no=100 → v1 stays 1 (first vote locks), v3v2v1=011, vot=1.
- Start; only btn_yes=001 at edge 2; TIMEOUT_CYCLES=16 → DONE after the 16th COLLECT edge, timeout=1, voted=001, v3v2v1=001, vot=0.
- Start; btn_yes=010 and btn_no=010 on the same edge → voted[1] stays 0; a later btn_no=010 records v2=0.
- Assert rst_n=0 mid-COLLECT, with voted=011 → all outputs 0 immediately (asynchronous); start pulses in COLLECT and DONE do not restart the session; busy=0 after reset release.
